// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Decodes PS/2 set-2 scancode byte streams into make/break
//                events and tracks the held state of five game keys.
//                Prefix bytes (E0 = extended, F0 = break) are collected by a
//                four-state FSM. A partial sequence is abandoned if the next
//                byte does not arrive within TIMEOUT_CYCLES clocks.
//  Ports       :
//    inclock         system clock, rising edge
//    resetn          synchronous active-low reset
//    scancode[7:0]   raw byte from the PS/2 controller
//    scancode_valid  one-cycle strobe qualifying scancode
//    p1_up/p1_down   held state of W (1D) / S (1B)
//    p2_up/p2_down   held state of E0 75 / E0 72 (arrow up / down)
//    start_key       held state of Space (29)
//    key_event       one-cycle strobe per completed make/break sequence
//    key_code[7:0]   final byte of the completed sequence
//    key_ext         completed sequence carried E0
//    key_release     completed sequence carried F0
//    overrun         sticky flag, set on keyboard error byte (00 / FF)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_key,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_next;

    logic is_ignored;
    logic is_error;
    logic is_brk_pfx;
    logic is_ext_pfx;
    logic complete;
    logic seq_ext;
    logic seq_rel;

    // Byte classification. Controller acknowledge/echo/resend/BAT bytes are
    // transparent to the decoder; 00/FF are keyboard buffer errors.
    always_comb begin
        is_ignored = 1'b0;
        is_error   = 1'b0;
        case (scancode)
            8'hAA, 8'hFA, 8'hEE, 8'hFE: is_ignored = 1'b1;
            8'h00, 8'hFF:               is_error   = 1'b1;
            default: ;
        endcase
        is_brk_pfx = (scancode == 8'hF0);
        is_ext_pfx = (scancode == 8'hE0);
    end

    // The prefixes seen so far are encoded directly in the state.
    assign seq_ext = (state == EXT) || (state == EXT_BRK);
    assign seq_rel = (state == BRK) || (state == EXT_BRK);

    // State register
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
        end
    end

    // Next-state logic. A valid byte always takes priority over timeout
    // expiry, so a byte arriving on the last allowed cycle is still decoded.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = '0;
        complete     = 1'b0;
        if (scancode_valid) begin
            if (is_error) begin
                state_next = IDLE;
            end else if (!is_ignored) begin
                case (state)
                    IDLE: begin
                        if (is_brk_pfx)      state_next = BRK;
                        else if (is_ext_pfx) state_next = EXT;
                        else                 complete   = 1'b1;
                    end
                    EXT: begin
                        if (is_brk_pfx)      state_next = EXT_BRK;
                        else if (is_ext_pfx) state_next = EXT;
                        else begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    BRK: begin
                        if (is_brk_pfx)      state_next = BRK;
                        else if (is_ext_pfx) state_next = EXT_BRK;
                        else begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (is_brk_pfx || is_ext_pfx) state_next = EXT_BRK;
                        else begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (state != IDLE) begin
            if (tmo_cnt == CNT_LAST) begin
                state_next = IDLE;
            end else begin
                tmo_cnt_next = tmo_cnt + CNT_ONE;
            end
        end
    end

    // Event, held-key and error outputs
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            key_event   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            p1_up       <= 1'b0;
            p1_down     <= 1'b0;
            p2_up       <= 1'b0;
            p2_down     <= 1'b0;
            start_key   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            key_event <= complete;
            if (complete) begin
                key_code    <= scancode;
                key_ext     <= seq_ext;
                key_release <= seq_rel;
                // Match on both code and extension so keypad 8 (75) or
                // E0 1D cannot alias onto a game key.
                if (!seq_ext && scancode == 8'h1D) p1_up     <= !seq_rel;
                if (!seq_ext && scancode == 8'h1B) p1_down   <= !seq_rel;
                if ( seq_ext && scancode == 8'h75) p2_up     <= !seq_rel;
                if ( seq_ext && scancode == 8'h72) p2_down   <= !seq_rel;
                if (!seq_ext && scancode == 8'h29) start_key <= !seq_rel;
            end
            if (scancode_valid && is_error) begin
                // Keyboard lost bytes: any held key may have been released
                // unseen, so drop them all.
                overrun   <= 1'b1;
                p1_up     <= 1'b0;
                p1_down   <= 1'b0;
                p2_up     <= 1'b0;
                p2_down   <= 1'b0;
                start_key <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_tracker
//  Description : Directed self-checking bench for ps2_key_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam int T = 16;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       scancode_valid = 1'b0;
    logic       p1_up, p1_down, p2_up, p2_down, start_key;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_ext, key_release, overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int ev_cnt = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .inclock        (inclock),
        .resetn         (resetn),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .p1_up          (p1_up),
        .p1_down        (p1_down),
        .p2_up          (p2_up),
        .p2_down        (p2_down),
        .start_key      (start_key),
        .key_event      (key_event),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_release    (key_release),
        .overrun        (overrun)
    );

    always #5 inclock = ~inclock;

    // Each key_event pulse spans exactly one negedge.
    always @(negedge inclock) if (key_event) ev_cnt++;

    function automatic logic [4:0] held();
        return {p1_up, p1_down, p2_up, p2_down, start_key};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge inclock);
        scancode       = b;
        scancode_valid = 1'b1;
        @(negedge inclock);
        scancode_valid = 1'b0;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge inclock);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge inclock);
        resetn = 1'b0;
        @(negedge inclock);
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        // reset must win over a simultaneous valid byte
        @(negedge inclock);
        resetn = 1'b0;
        scancode = 8'h1D;
        scancode_valid = 1'b1;
        @(negedge inclock);
        @(negedge inclock);
        resetn = 1'b1;
        scancode_valid = 1'b0;
        #1;
        n_cmp++;
        if ({held(), key_event, key_ext, key_release, overrun} !== 9'b0) begin
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {held(), key_event, key_ext, key_release, overrun});
            n_fail++;
        end
        n_cmp++;
        if (key_code !== 8'h00) begin
            $display("FAIL reset_key_code: got %h expected 00", key_code);
            n_fail++;
        end
    endtask

    task automatic test_make_break();
        int e0;
        send_byte(8'h1D);
        n_cmp++;
        if ({key_event, key_code, key_ext, key_release, held()} !== {1'b1, 8'h1D, 2'b00, 5'b10000}) begin
            $display("FAIL make_1d: got ev=%b code=%h ext=%b rel=%b held=%b expected 1 1d 0 0 10000",
                     key_event, key_code, key_ext, key_release, held());
            n_fail++;
        end
        step(1);
        n_cmp++;
        if ({key_event, key_code} !== {1'b0, 8'h1D}) begin
            $display("FAIL event_one_cycle_code_hold: got ev=%b code=%h expected 0 1d", key_event, key_code);
            n_fail++;
        end
        e0 = ev_cnt;
        send_byte(8'hF0);
        n_cmp++;
        if (ev_cnt - e0 !== 0) begin
            $display("FAIL prefix_no_event: got %0d events expected 0", ev_cnt - e0);
            n_fail++;
        end
        send_byte(8'h1D);
        n_cmp++;
        if ({key_event, key_code, key_ext, key_release, held()} !== {1'b1, 8'h1D, 2'b01, 5'b00000}) begin
            $display("FAIL break_1d: got ev=%b code=%h ext=%b rel=%b held=%b expected 1 1d 0 1 00000",
                     key_event, key_code, key_ext, key_release, held());
            n_fail++;
        end
    endtask

    task automatic test_extended();
        send_byte(8'hE0); send_byte(8'h72);
        n_cmp++;
        if ({key_event, key_code, key_ext, key_release, held()} !== {1'b1, 8'h72, 2'b10, 5'b00010}) begin
            $display("FAIL ext_make_72: got ev=%b code=%h ext=%b rel=%b held=%b expected 1 72 1 0 00010",
                     key_event, key_code, key_ext, key_release, held());
            n_fail++;
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        n_cmp++;
        if ({key_event, key_code, key_ext, key_release, held()} !== {1'b1, 8'h72, 2'b11, 5'b00000}) begin
            $display("FAIL ext_break_72: got ev=%b code=%h ext=%b rel=%b held=%b expected 1 72 1 1 00000",
                     key_event, key_code, key_ext, key_release, held());
            n_fail++;
        end
        send_byte(8'h72);
        n_cmp++;
        if ({key_event, key_ext, held()} !== {2'b10, 5'b00000}) begin
            $display("FAIL plain_72: got ev=%b ext=%b held=%b expected 1 0 00000", key_event, key_ext, held());
            n_fail++;
        end
        send_byte(8'hF0); send_byte(8'h72);
        send_byte(8'h75);
        n_cmp++;
        if (held() !== 5'b00000) begin
            $display("FAIL keypad_75_alias: got held=%b expected 00000", held());
            n_fail++;
        end
        send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h1D);
        n_cmp++;
        if ({key_ext, held()} !== {1'b1, 5'b00000}) begin
            $display("FAIL ext_1d_alias: got ext=%b held=%b expected 1 00000", key_ext, held());
            n_fail++;
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1D);
        send_byte(8'hE0); send_byte(8'h75);
        n_cmp++;
        if (held() !== 5'b00100) begin
            $display("FAIL ext_make_75: got held=%b expected 00100", held());
            n_fail++;
        end
        // E0 after F0 is also an extended break
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        n_cmp++;
        if ({key_ext, key_release, held()} !== {2'b11, 5'b00000}) begin
            $display("FAIL f0_e0_break_75: got ext=%b rel=%b held=%b expected 1 1 00000",
                     key_ext, key_release, held());
            n_fail++;
        end
    endtask

    task automatic test_typematic();
        int e0;
        e0 = ev_cnt;
        send_byte(8'h29); send_byte(8'h29);
        n_cmp++;
        if ({ev_cnt - e0, held()} !== {32'd2, 5'b00001}) begin
            $display("FAIL typematic: got events=%0d held=%b expected 2 00001", ev_cnt - e0, held());
            n_fail++;
        end
        send_byte(8'hF0); send_byte(8'h29);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = ev_cnt;
        send_byte(8'hE0);
        step(T - 1);          // T idle edges: prefix discarded
        n_cmp++;
        if (ev_cnt - e0 !== 0) begin
            $display("FAIL timeout_no_event: got %0d events expected 0", ev_cnt - e0);
            n_fail++;
        end
        send_byte(8'h1B);
        n_cmp++;
        if ({key_event, key_code, key_ext, key_release, held()} !== {1'b1, 8'h1B, 2'b00, 5'b01000}) begin
            $display("FAIL timeout_then_1b: got ev=%b code=%h ext=%b rel=%b held=%b expected 1 1b 0 0 01000",
                     key_event, key_code, key_ext, key_release, held());
            n_fail++;
        end
        // byte arrives on the expiry cycle: still extended
        send_byte(8'hE0);
        step(T - 2);          // T-1 idle edges
        send_byte(8'h72);
        n_cmp++;
        if ({key_ext, held()} !== {1'b1, 5'b01010}) begin
            $display("FAIL timeout_coincide: got ext=%b held=%b expected 1 01010", key_ext, held());
            n_fail++;
        end
        // break prefix timing out turns the next byte into a make
        send_byte(8'hF0);
        step(T - 1);
        send_byte(8'h1D);
        n_cmp++;
        if ({key_release, held()} !== {1'b0, 5'b11010}) begin
            $display("FAIL brk_timeout: got rel=%b held=%b expected 0 11010", key_release, held());
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        int e0;
        send_byte(8'h29);
        n_cmp++;
        if ({held(), overrun} !== {5'b11011, 1'b0}) begin
            $display("FAIL pre_overrun_held: got held=%b ovr=%b expected 11011 0", held(), overrun);
            n_fail++;
        end
        e0 = ev_cnt;
        send_byte(8'h00);
        n_cmp++;
        if ({held(), overrun, ev_cnt - e0} !== {5'b00000, 1'b1, 32'd0}) begin
            $display("FAIL overrun_00: got held=%b ovr=%b events=%0d expected 00000 1 0",
                     held(), overrun, ev_cnt - e0);
            n_fail++;
        end
        send_byte(8'h29);
        n_cmp++;
        if ({held(), overrun} !== {5'b00001, 1'b1}) begin
            $display("FAIL after_overrun_29: got held=%b ovr=%b expected 00001 1", held(), overrun);
            n_fail++;
        end
        // FF mid-sequence drops the E0 prefix
        send_byte(8'hE0); send_byte(8'hFF); send_byte(8'h72);
        n_cmp++;
        if ({key_code, key_ext, held(), overrun} !== {8'h72, 1'b0, 5'b00000, 1'b1}) begin
            $display("FAIL ff_mid_seq: got code=%h ext=%b held=%b ovr=%b expected 72 0 00000 1",
                     key_code, key_ext, held(), overrun);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_seq();
        send_byte(8'hF0);
        pulse_reset();
        n_cmp++;
        if (overrun !== 1'b0) begin
            $display("FAIL reset_clears_overrun: got %b expected 0", overrun);
            n_fail++;
        end
        send_byte(8'h1D);
        n_cmp++;
        if ({key_event, key_release, held()} !== {2'b10, 5'b10000}) begin
            $display("FAIL reset_mid_seq: got ev=%b rel=%b held=%b expected 1 0 10000",
                     key_event, key_release, held());
            n_fail++;
        end
    endtask

    task automatic test_ignored();
        int e0;
        e0 = ev_cnt;
        send_byte(8'hF0); send_byte(8'hFA); send_byte(8'h1D);
        n_cmp++;
        if ({ev_cnt - e0, key_release, held()} !== {32'd1, 1'b1, 5'b00000}) begin
            $display("FAIL ignored_in_seq: got events=%0d rel=%b held=%b expected 1 1 00000",
                     ev_cnt - e0, key_release, held());
            n_fail++;
        end
        e0 = ev_cnt;
        send_byte(8'hAA); send_byte(8'hEE); send_byte(8'hFE);
        n_cmp++;
        if ({ev_cnt - e0, key_code, overrun} !== {32'd0, 8'h1D, 1'b0}) begin
            $display("FAIL ignored_idle: got events=%0d code=%h ovr=%b expected 0 1d 0",
                     ev_cnt - e0, key_code, overrun);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_typematic();
        test_timeout();
        test_overrun();
        test_reset_mid_seq();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1000000, max inclock cycles allowed between prefix byte and next byte before the partial sequence is discarded.
REQ-002 inclock  input  1  system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 scancode  input  8  raw byte from the PS/2 controller.
REQ-005 scancode_valid  input  1  one-cycle strobe; scancode is valid when high.
REQ-006 p1_up, p1_down  output  1 each  held state of W (0x1D) and S (0x1B).
REQ-007 p2_up, p2_down  output  1 each  held state of Up arrow (E0 75) and Down arrow (E0 72).
REQ-008 start_key  output  1  held state of Space (0x29).
REQ-009 key_event  output  1  one-cycle strobe per completed make or break sequence, any key.
REQ-010 key_code  output  8  final byte of the completed sequence, valid with key_event.
REQ-011 key_ext  output  1  sequence carried E0 prefix, valid with key_event.
REQ-012 key_release  output  1  sequence carried F0 prefix, valid with key_event.
REQ-013 overrun  output  1  sticky flag, set on keyboard error byte.

Function
REQ-014 The decoder SHALL be a four-state FSM: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
REQ-015 Transitions on scancode_valid only:
- IDLE: F0 -> BRK; E0 -> EXT; other -> complete make, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other -> complete extended make, -> IDLE.
- BRK: F0 -> BRK; E0 -> EXT_BRK; other -> complete break, -> IDLE.
- EXT_BRK: F0 or E0 -> EXT_BRK; other -> complete extended break, -> IDLE.
REQ-016 Bytes 0xAA, 0xFA, 0xEE, 0xFE SHALL be ignored in every state with no state change and no key_event.
REQ-017 Bytes 0x00 and 0xFF SHALL set overrun, clear all five held-key outputs, and force IDLE, in any state.
REQ-018 A completed sequence SHALL assert key_event for exactly one cycle, the cycle after the final byte's scancode_valid, with key_code, key_ext, key_release registered alongside.
REQ-019 Held-key outputs SHALL update in the same cycle as key_event: make sets, break clears the matching bit.
REQ-020 Matching is exact on ext: 0x75 without E0 (keypad 8) SHALL NOT affect p2_up; E0 1D SHALL NOT affect p1_up.
REQ-021 Typematic repeat (make of an already-held key) SHALL produce key_event; held output stays 1.
REQ-022 A timeout counter SHALL run while in EXT, BRK, or EXT_BRK, reload to 0 on every scancode_valid, and on reaching TIMEOUT_CYCLES-1 force IDLE with no key_event and no held-state change.
REQ-023 Timeout counter SHALL be held at 0 in IDLE; width ceil(log2(TIMEOUT_CYCLES)) bits, no wrap.
REQ-024 If scancode_valid coincides with timeout expiry, the byte SHALL be processed and the timeout ignored.
REQ-025 overrun SHALL clear only on reset.
REQ-026 key_code, key_ext, key_release SHALL hold their last value between events.

Reset
REQ-027 With resetn low at a rising edge: state IDLE, timeout counter 0, all outputs 0 including overrun, key_code 0x00; reset overrides scancode_valid in the same cycle.
REQ-028 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; next byte is decoded from IDLE.

Verification
REQ-029 1D -> key_event, key_code 0x1D, ext 0, release 0, p1_up 1; then F0 1D -> key_event, release 1, p1_up 0.
REQ-030 E0 72, then E0 F0 72 -> p2_down 1 then 0; key_ext 1 on both events; plain 72 leaves p2_down 0.
REQ-031 E0, no further byte for TIMEOUT_CYCLES cycles, then 1B -> no event on timeout; 1B decoded as plain make, p1_down 1.
REQ-032 Hold 29, 1D, 1B; send 0x00 -> overrun 1, all held outputs 0, no key_event; next 29 -> start_key 1, overrun still 1.
REQ-033 F0 then resetn low one cycle, then 1D -> p1_up 1 (make, not break).
REQ-034 Interleave 0xFA between F0 and 1D -> treated as F0 1D; p1_up cleared, single key_event.
